// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard between decode and execute: per-register write-back countdowns,
// RAW/WAW stall generation, flush, and a saturating stall counter. Optional: SCOREBOARD_FWD_EN.
module issue_scoreboard #(
    parameter int NUM_REGS    = 8,
    parameter int REG_W       = 3,
    parameter int LAT_W       = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dec_valid,
    input  logic [REG_W-1:0]       dec_rs1,
    input  logic [REG_W-1:0]       dec_rs2,
    input  logic [REG_W-1:0]       dec_rd,
    input  logic                   dec_use_rs1,
    input  logic                   dec_use_rs2,
    input  logic                   dec_wr_rd,
    input  logic [LAT_W-1:0]       dec_latency,
    input  logic                   flush,
    output logic                   issue,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] eff_lat;
    logic             rs1_pend;
    logic             rs2_pend;
    logic             raw_hazard;
    logic             waw_hazard;

    // A zero latency still occupies the register for one cycle.
    assign eff_lat = (dec_latency == '0) ? LAT_W'(1) : dec_latency;

`ifdef SCOREBOARD_FWD_EN
    // A source one cycle from write-back is picked up by the forwarding path.
    assign rs1_pend = (cnt[dec_rs1] > LAT_W'(1));
    assign rs2_pend = (cnt[dec_rs2] > LAT_W'(1));
`else
    assign rs1_pend = (cnt[dec_rs1] != '0);
    assign rs2_pend = (cnt[dec_rs2] != '0);
`endif

    assign raw_hazard = (dec_use_rs1 & rs1_pend) | (dec_use_rs2 & rs2_pend);
    // The younger write must not land before an older write to the same register.
    assign waw_hazard = dec_wr_rd & (cnt[dec_rd] > eff_lat);

    assign stall = dec_valid & (raw_hazard | waw_hazard) & ~flush;
    assign issue = dec_valid & ~stall & ~flush;

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // NOTE: the countdown array is architectural state and must be cleared on reset,
    // unlike a data RAM; a stale nonzero count would stall decode forever.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (issue && dec_wr_rd && (dec_rd == REG_W'(r))) begin
                    cnt[r] <= eff_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (dec_valid && stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; a second instance with a 4-bit stall counter
// shares the stimulus to exercise counter saturation.
module tb_issue_scoreboard;

`ifdef SCOREBOARD_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [2:0]  dec_rs1;
    logic [2:0]  dec_rs2;
    logic [2:0]  dec_rd;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        dec_wr_rd;
    logic [2:0]  dec_latency;
    logic        flush;
    logic        issue;
    logic        stall;
    logic [7:0]  busy_mask;
    logic [15:0] stall_count;
    logic        sat_issue;
    logic        sat_stall;
    logic [7:0]  sat_busy_mask;
    logic [3:0]  sat_stall_count;

    int n_chk;
    int n_err;
    int exp_stall;

    issue_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_wr_rd   (dec_wr_rd),
        .dec_latency (dec_latency),
        .flush       (flush),
        .issue       (issue),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .stall_count (stall_count)
    );

    issue_scoreboard #(.STALL_CNT_W(4)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_wr_rd   (dec_wr_rd),
        .dec_latency (dec_latency),
        .flush       (flush),
        .issue       (sat_issue),
        .stall       (sat_stall),
        .busy_mask   (sat_busy_mask),
        .stall_count (sat_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2,
                         input logic [2:0] rd, input logic wr, input logic [2:0] lat);
        dec_valid   = v;
        dec_rs1     = rs1;
        dec_use_rs1 = u1;
        dec_rs2     = rs2;
        dec_use_rs2 = u2;
        dec_rd      = rd;
        dec_wr_rd   = wr;
        dec_latency = lat;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_stall_count"}, 32'(stall_count), 32'(exp_stall));
        check({tag, "_sat_count"}, 32'(sat_stall_count), (exp_stall > 15) ? 32'd15 : 32'(exp_stall));
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        exp_stall = 0;
        flush     = 1'b0;
        reset     = 1'b0;
        idle();

        // Reset held with a valid instruction present
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        check("rst_busy", 32'(busy_mask), 32'h00);
        check("rst_stall", 32'(stall), 32'd0);
        check_counts("rst");
        tick();
        tick();
        check("rst_busy_held", 32'(busy_mask), 32'h00);
        reset = 1'b1;
        #1;
        check("post_rst_issue", 32'(issue), 32'd1);
        check("post_rst_stall", 32'(stall), 32'd0);
        tick();

        // RAW: writer r3 latency 3, then a reader of r3
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd3);
        check("raw_writer_issue", 32'(issue), 32'd1);
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int c = 3; c >= FWD; c--) begin
            check("raw_stall", 32'(stall), 32'(c > FWD));
            check("raw_issue", 32'(issue), 32'(c == FWD));
            check("raw_busy", 32'(busy_mask), (c != 0) ? 32'h08 : 32'h00);
            if (c > FWD) exp_stall++;
            tick();
        end
        idle();
        check_counts("raw");

        // WAW: writer r5 latency 6, then a writer r5 latency 2
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd6);
        check("waw_first_issue", 32'(issue), 32'd1);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd2);
        for (int c = 6; c >= 2; c--) begin
            check("waw_stall", 32'(stall), 32'(c > 2));
            check("waw_issue", 32'(issue), 32'(c == 2));
            if (c > 2) exp_stall++;
            tick();
        end
        idle();
        check("waw_reload_busy", 32'(busy_mask), 32'h20);
        tick();
        check("waw_reload_busy_2", 32'(busy_mask), 32'h20);
        tick();
        check("waw_drained", 32'(busy_mask), 32'h00);
        check_counts("waw");

        // Flush with three writers pending and a simultaneous would-be load
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd7);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 3'd7);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 3'd7);
        tick();
        idle();
        check("flush_pre_busy", 32'(busy_mask), 32'h16);
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 3'd3);
        flush = 1'b1;
        #1;
        check("flush_issue", 32'(issue), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        idle();
        check("flush_busy", 32'(busy_mask), 32'h00);
        check_counts("flush");

        // Latency 0 with rd == rs1, then an immediate dependent read
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0);
        check("lat0_issue", 32'(issue), 32'd1);
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        check("lat0_busy", 32'(busy_mask), 32'h04);
        check("lat0_dep_stall", 32'(stall), 32'(FWD == 0));
        check("lat0_dep_issue", 32'(issue), 32'(FWD == 1));
        if (FWD == 0) begin
            exp_stall++;
            tick();
            check("lat0_dep_issue_late", 32'(issue), 32'd1);
        end
        tick();
        idle();
        check("lat0_drained", 32'(busy_mask), 32'h00);
        check_counts("lat0");

        // WAW boundary: pending count 1 against a latency-0 (effective 1) write
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 3'd1);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 3'd0);
        check("waw_edge_stall", 32'(stall), 32'd0);
        check("waw_edge_issue", 32'(issue), 32'd1);
        tick();
        idle();
        check("waw_edge_busy", 32'(busy_mask), 32'h80);
        tick();
        check("waw_edge_drained", 32'(busy_mask), 32'h00);

        // Long RAW stalls drive the 4-bit counter into saturation
        for (int round = 0; round < 3; round++) begin
            drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7);
            check("sat_writer_issue", 32'(issue), 32'd1);
            tick();
            drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
            for (int c = 7; c >= FWD; c--) begin
                check("sat_raw_stall", 32'(stall), 32'(c > FWD));
                if (c > FWD) exp_stall++;
                tick();
            end
            idle();
            check_counts("sat_round");
        end
        tick();
        tick();
        check("sat_held", 32'(sat_stall_count), 32'd15);

        // Asynchronous reset mid-operation
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd7);
        tick();
        idle();
        check("midrst_pre_busy", 32'(busy_mask), 32'h08);
        #2;
        reset = 1'b0;
        #1;
        exp_stall = 0;
        check("midrst_busy", 32'(busy_mask), 32'h00);
        check_counts("midrst");
        #2;
        reset = 1'b1;
        tick();
        check("midrst_after_busy", 32'(busy_mask), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
